// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven sequencer for a shared up/down counter.
// Accepts one {start, steps, dir, wrap_en} command at a time, loads the
// counter, counts it the requested number of steps, then pulses done.
// A non-wrapping run that reaches 0 or 2^WIDTH-1 stops early and sets err.
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   cmd_valid/ready    command handshake; ready only while IDLE
//   cmd_start/steps    load value and number of steps to count
//   cmd_dir            1 = up, 0 = down
//   cmd_wrap_en        1 = let the counter wrap modulo 2^WIDTH
//   pause              freezes counting while high
//   load_n/ce/up_down/data_load   counter controls
//   max_count/zero     counter boundary flags
//   busy/done/err/steps_left      status
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             cmd_wrap_en,
  input  logic             pause,
  output logic             load_n,
  output logic             ce,
  output logic             up_down,
  output logic [WIDTH-1:0] data_load,
  input  logic             max_count,
  input  logic             zero,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] start_q;
  logic             dir_q;
  logic             wrap_q;
  logic             blocked_c;
  logic             run_ce_c;

  // Boundary stop: next step would wrap and wrapping is not allowed.
  always_comb begin
    blocked_c = 1'b0;
    run_ce_c  = 1'b0;
    blocked_c = !wrap_q && ((dir_q && max_count) || (!dir_q && zero));
    run_ce_c  = (state == S_RUN) && !pause && !blocked_c;
  end

  // Counter controls and status decode from state and latched fields.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    load_n    = (state != S_LOAD);
    ce        = run_ce_c;
    up_down   = (state == S_RUN) ? dir_q : 1'b1;
    data_load = start_q;
  end

  // Sequencer state, latched command and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_q    <= '0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
      err        <= 1'b0;
      steps_left <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            start_q    <= cmd_start;
            dir_q      <= cmd_dir;
            wrap_q     <= cmd_wrap_en;
            steps_left <= cmd_steps;
            err        <= 1'b0;
            state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          // steps_left still holds the full step count here.
          state <= (steps_left == '0) ? S_DONE : S_RUN;
        end
        S_RUN: begin
          // While paused nothing moves and the boundary is not checked.
          if (!pause) begin
            if (blocked_c) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              steps_left <= steps_left - WIDTH'(1);
              if (steps_left == WIDTH'(1)) begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: a behavioural up/down counter closes the loop,
// a directed vector table and random commands are checked against a
// step-by-step model of the command semantics.
module tb_counter_seq_ctrl;

  localparam int unsigned W    = 4;
  localparam int          MAXV = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_start;
  logic [W-1:0] cmd_steps;
  logic         cmd_dir;
  logic         cmd_wrap_en;
  logic         pause;
  logic         load_n;
  logic         ce;
  logic         up_down;
  logic [W-1:0] data_load;
  logic         max_count;
  logic         zero;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] steps_left;
  logic [W-1:0] count;

  int checks = 0;
  int errors = 0;

  counter_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_steps  (cmd_steps),
    .cmd_dir    (cmd_dir),
    .cmd_wrap_en(cmd_wrap_en),
    .pause      (pause),
    .load_n     (load_n),
    .ce         (ce),
    .up_down    (up_down),
    .data_load  (data_load),
    .max_count  (max_count),
    .zero       (zero),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .steps_left (steps_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: the shared up/down counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count <= '0;
    else if (!load_n) count <= data_load;
    else if (ce)      count <= up_down ? count + 4'd1 : count - 4'd1;
  end
  assign max_count = (count == 4'hF);
  assign zero      = (count == 4'h0);

  typedef struct {
    int done_k;   // cycles after acceptance edge at which done is seen
    int cnt;
    int er;
    int left;
    int nce;
  } res_t;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] st;
    logic         d;
    logic         w;
    logic [31:0]  pm;  // bit i = pause high in cycle T+2+i
    int           dk;
    int           cnt;
    int           er;
    int           left;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Walk the command one cycle at a time from the first RUN cycle (T+2).
  function automatic res_t model(input int s, input int st, input int d,
                                 input int w, input logic [31:0] pm);
    res_t r;
    int pos = s;
    int rem = st;
    int k = 2;
    r.er = 0;
    while (rem > 0 && r.er == 0) begin
      if (k - 2 < 32 && pm[5'(k - 2)]) begin
        k++;
      end else if (w == 0 && ((d != 0 && pos == MAXV) || (d == 0 && pos == 0))) begin
        r.er = 1;
        k++;
      end else begin
        pos = (d != 0) ? (pos + 1) % (MAXV + 1) : (pos + MAXV) % (MAXV + 1);
        rem--;
        k++;
      end
    end
    r.done_k = k;
    r.cnt    = pos;
    r.left   = rem;
    r.nce    = st - rem;
    return r;
  endfunction

  // Issue one command and follow it to done; with hold, cmd_valid stays high
  // with different fields and is accepted in the IDLE cycle after done.
  task automatic run_cmd(input logic [W-1:0] s, input logic [W-1:0] st,
                         input logic d, input logic w, input logic [31:0] pm,
                         input res_t e, input bit hold);
    int  k;
    int  ce_n;
    bit  seen;
    @(negedge clk);
    chk("ready_idle", int'(cmd_ready), 1);
    cmd_valid   = 1'b1;
    cmd_start   = s;
    cmd_steps   = st;
    cmd_dir     = d;
    cmd_wrap_en = w;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_start   = ~s;
      cmd_steps   = 4'd2;
      cmd_dir     = ~d;
      cmd_wrap_en = 1'b1;
    end else begin
      cmd_valid = 1'b0;
    end
    k = 1; ce_n = 0; seen = 0;
    while (!seen && k < 100) begin
      pause = (k >= 2 && k - 2 < 32) ? pm[5'(k - 2)] : 1'b0;
      @(negedge clk);
      if (k == 1) begin
        chk("load_low", int'(load_n), 0);
        chk("load_value", int'(data_load), int'(s));
        chk("err_cleared", int'(err), 0);
      end
      chk("ready_busy", int'(cmd_ready), 0);
      chk("ce_with_load", int'(ce & ~load_n), 0);
      chk("ce_at_bound", int'(ce && !w && ((d && max_count) || (!d && zero))), 0);
      if (ce) ce_n++;
      if (done) begin
        seen = 1;
        chk("done_cycle", k, e.done_k);
        chk("done_count", int'(count), e.cnt);
        chk("done_err", int'(err), e.er);
        chk("done_left", int'(steps_left), e.left);
        chk("ce_cycles", ce_n, e.nce);
      end
      @(posedge clk);
      #1;
      k++;
    end
    pause = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done at %0d", e.done_k);
    end
    @(negedge clk);
    chk("idle_ready", int'(cmd_ready), 1);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("hold_err", int'(err), e.er);
    chk("hold_left", int'(steps_left), e.left);
  endtask

  vec_t vecs[8];
  res_t r;

  initial begin
    // Directed vectors with hand-derived expectations.
    vecs[0] = '{4'd3,  4'd5, 1'b1, 1'b0, 32'h0,  7, 8,  0, 0};
    vecs[1] = '{4'd1,  4'd3, 1'b0, 1'b1, 32'h0,  5, 14, 0, 0};
    vecs[2] = '{4'd13, 4'd5, 1'b1, 1'b0, 32'h0,  5, 15, 1, 3};
    vecs[3] = '{4'd0,  4'd4, 1'b1, 1'b0, 32'h1C, 9, 4,  0, 0};
    vecs[4] = '{4'd7,  4'd0, 1'b1, 1'b0, 32'h0,  2, 7,  0, 0};
    vecs[5] = '{4'd0,  4'd3, 1'b0, 1'b0, 32'h0,  3, 0,  1, 3};
    vecs[6] = '{4'd15, 4'd2, 1'b1, 1'b1, 32'h0,  4, 1,  0, 0};
    vecs[7] = '{4'd14, 4'd4, 1'b1, 1'b0, 32'h2,  5, 15, 1, 3};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_start = '0; cmd_steps = '0;
    cmd_dir = 1'b0; cmd_wrap_en = 1'b0; pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_n", int'(load_n), 1);
    chk("rst_ce", int'(ce), 0);
    chk("rst_up_down", int'(up_down), 1);
    chk("rst_data_load", int'(data_load), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_left", int'(steps_left), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(cmd_ready), 1);

    for (int i = 0; i < 8; i++) begin
      r.done_k = vecs[i].dk;
      r.cnt    = vecs[i].cnt;
      r.er     = vecs[i].er;
      r.left   = vecs[i].left;
      r.nce    = int'(vecs[i].st) - vecs[i].left;
      run_cmd(vecs[i].s, vecs[i].st, vecs[i].d, vecs[i].w, vecs[i].pm, r, 1'b0);
    end

    // Command held during RUN is ignored, then taken in the next IDLE cycle.
    r = model(6, 3, 1, 0, 32'h0);
    run_cmd(4'd6, 4'd3, 1'b1, 1'b0, 32'h0, r, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("held_cmd_load", int'(load_n), 0);
    chk("held_cmd_value", int'(data_load), 9);
    begin
      bool_wait : for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (done) break;
      end
    end
    chk("held_cmd_done", int'(done), 1);
    chk("held_cmd_count", int'(count), 7);
    chk("held_cmd_err", int'(err), 0);

    // Reset in the middle of RUN aborts with no done pulse.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_start = 4'd2; cmd_steps = 4'd10;
    cmd_dir = 1'b1; cmd_wrap_en = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ce", int'(ce), 0);
    chk("midrst_load_n", int'(load_n), 1);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_left", int'(steps_left), 0);
    chk("midrst_up_down", int'(up_down), 1);
    chk("midrst_data_load", int'(data_load), 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("midrst_no_done", int'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready_after", int'(cmd_ready), 1);
    chk("midrst_done_after", int'(done), 0);

    // Random commands against the model.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] s, st;
      logic         d, w;
      logic [31:0]  pm;
      s  = W'($urandom_range(0, MAXV));
      st = W'($urandom_range(0, MAXV));
      d  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      pm = $urandom & $urandom & $urandom;
      r  = model(int'(s), int'(st), int'(d), int'(w), pm);
      run_cmd(s, st, d, w, pm, r, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
